// File: rtl/base_skid_reg.sv
// Two-entry valid/ready skid buffer. in_rdy is registered, so there is no
// combinational path from out_rdy back to the producer.
module base_skid_reg #(
  parameter int unsigned WID = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           in_vld,
  output logic           in_rdy,
  input  logic [WID-1:0] in_data,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [WID-1:0] out_data,
  output logic [1:0]     cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_in_rdy;
  logic           r_out_vld;
  logic [WID-1:0] r_main;
  logic [WID-1:0] r_skid;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  always_comb begin
    w_in_xfer        = in_vld & r_in_rdy;
    w_out_xfer       = r_out_vld & out_rdy;
    w_next           = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (clr) begin
      w_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_next         = ONE;
            w_load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_load_main_in = 1'b1;
          end else if (w_in_xfer) begin
            w_next      = FULL;
            w_load_skid = 1'b1;
          end else if (w_out_xfer) begin
            w_next = EMPTY;
          end
        end
        FULL: begin
          // in_rdy is low here, so only the drain case exists
          if (w_out_xfer) begin
            w_next           = ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_in_rdy  <= 1'b0;
      r_out_vld <= 1'b0;
      r_main    <= '0;
      r_skid    <= '0;
    end else begin
      r_state   <= w_next;
      r_in_rdy  <= (w_next != FULL);
      r_out_vld <= (w_next != EMPTY);
      if (w_load_main_in)
        r_main <= in_data;
      else if (w_load_main_skid)
        r_main <= r_skid;
      if (w_load_skid)
        r_skid <= in_data;
    end
  end

  assign in_rdy   = r_in_rdy;
  assign out_vld  = r_out_vld;
  assign out_data = r_main;
  assign cnt      = r_state;

endmodule
